// File: rtl/oled_i2c_rx.sv
// oled_i2c_rx: I2C slave receiver decoding the SSD1306 write stream into (col,row,data) writes and commands.
// Define OLED_RX_ACK_EN to let sda_oe acknowledge bytes; without it the block is a passive sniffer.
module oled_i2c_rx #(
  parameter logic [6:0] DEV_ADDR    = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [6:0] wr_col,
  output logic [2:0] wr_row,
  output logic [7:0] wr_data,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       frame_done,
  output logic       nack_err
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, CTRL, ACK_C, BYTE, ACK_B, IGNORE
  } state_t;

`ifdef OLED_RX_ACK_EN
  localparam logic ACK_DRIVE = 1'b1;
`else
  localparam logic ACK_DRIVE = 1'b0;
`endif

  localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       co_q, co_d;
  logic       dc_q, dc_d;
  logic       ack_hi_q, ack_hi_d;

  logic       sda_oe_q, sda_oe_d;
  logic       wr_en_q, wr_en_d;
  logic [6:0] wr_col_q, wr_col_d;
  logic [2:0] wr_row_q, wr_row_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [7:0] cmd_byte_q, cmd_byte_d;
  logic       frame_done_q, frame_done_d;
  logic       nack_err_q, nack_err_d;

  logic [6:0] ptr_col_q, ptr_col_d;
  logic [2:0] ptr_page_q, ptr_page_d;
  logic [6:0] col_start_q, col_start_d;
  logic [6:0] col_end_q, col_end_d;
  logic [2:0] page_start_q, page_start_d;
  logic [2:0] page_end_q, page_end_d;
  logic [1:0] arg_cnt_q, arg_cnt_d;
  logic       arg_page_q, arg_page_d;
  logic [6:0] arg0_q, arg0_d;

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, sda_rise, sda_fall;
  logic       start_det, stop_det;
  logic [7:0] byte_in;
  state_t     ack_next;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    scl_rise   = scl_s & ~scl_prev_q;
    scl_fall   = ~scl_s & scl_prev_q;
    sda_rise   = sda_s & ~sda_prev_q;
    sda_fall   = ~sda_s & sda_prev_q;
    // scl must be high on both sides of the sda edge, so an scl edge in the same clk wins as a data bit
    start_det  = sda_fall & scl_s & scl_prev_q;
    stop_det   = sda_rise & scl_s & scl_prev_q;
    byte_in    = {shift_q[6:0], sda_s};
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    co_d         = co_q;
    dc_d         = dc_q;
    ack_hi_d     = ack_hi_q;
    sda_oe_d     = sda_oe_q;
    wr_en_d      = 1'b0;
    wr_col_d     = wr_col_q;
    wr_row_d     = wr_row_q;
    wr_data_d    = wr_data_q;
    cmd_valid_d  = 1'b0;
    cmd_byte_d   = cmd_byte_q;
    frame_done_d = 1'b0;
    nack_err_d   = nack_err_q;
    ptr_col_d    = ptr_col_q;
    ptr_page_d   = ptr_page_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    arg_cnt_d    = arg_cnt_q;
    arg_page_d   = arg_page_q;
    arg0_d       = arg0_q;
    ack_next     = BYTE;

    case (state_q)
      ACK_A:   ack_next = CTRL;
      ACK_C:   ack_next = BYTE;
      ACK_B:   ack_next = co_q ? CTRL : BYTE;
      default: ack_next = BYTE;
    endcase

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      ack_hi_d  = 1'b0;
      sda_oe_d  = 1'b0;
      arg_cnt_d = 2'd0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      ack_hi_d  = 1'b0;
      sda_oe_d  = 1'b0;
      arg_cnt_d = 2'd0;
    end else begin
      case (state_q)
        ADDR, CTRL, BYTE: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                if (byte_in == {DEV_ADDR, 1'b0}) begin
                  state_d = ACK_A;
                end else begin
                  nack_err_d = 1'b1;
                  state_d    = IGNORE;
                end
              end else if (state_q == CTRL) begin
                co_d    = byte_in[7];
                dc_d    = byte_in[6];
                state_d = ACK_C;
              end else begin
                state_d = ACK_B;
                if (dc_q) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = byte_in;
                  wr_col_d  = ptr_col_q;
                  wr_row_d  = ptr_page_q;
                  arg_cnt_d = 2'd0;
                  // >= rather than == so an inverted window snaps back to start on every byte
                  if (ptr_col_q >= col_end_q) begin
                    ptr_col_d = col_start_q;
                    if (ptr_page_q >= page_end_q) begin
                      ptr_page_d   = page_start_q;
                      frame_done_d = 1'b1;
                    end else begin
                      ptr_page_d = ptr_page_q + 3'd1;
                    end
                  end else begin
                    ptr_col_d = ptr_col_q + 7'd1;
                  end
                end else begin
                  cmd_valid_d = 1'b1;
                  cmd_byte_d  = byte_in;
                  case (arg_cnt_q)
                    2'd0: begin
                      if (byte_in == CMD_COL_ADDR) begin
                        arg_cnt_d  = 2'd1;
                        arg_page_d = 1'b0;
                      end else if (byte_in == CMD_PAGE_ADDR) begin
                        arg_cnt_d  = 2'd1;
                        arg_page_d = 1'b1;
                      end
                    end
                    2'd1: begin
                      arg0_d    = byte_in[6:0];
                      arg_cnt_d = 2'd2;
                    end
                    default: begin
                      arg_cnt_d = 2'd0;
                      if (arg_page_q) begin
                        page_start_d = arg0_q[2:0];
                        page_end_d   = byte_in[2:0];
                        ptr_page_d   = arg0_q[2:0];
                      end else begin
                        col_start_d = arg0_q;
                        col_end_d   = byte_in[6:0];
                        ptr_col_d   = arg0_q;
                      end
                    end
                  endcase
                end
              end
            end
          end
        end
        ACK_A, ACK_C, ACK_B: begin
          // first scl fall opens the 9th-bit ACK window, the next one closes it
          if (scl_fall) begin
            if (!ack_hi_q) begin
              ack_hi_d = 1'b1;
              sda_oe_d = ACK_DRIVE;
            end else begin
              ack_hi_d  = 1'b0;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = ack_next;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      co_q         <= 1'b0;
      dc_q         <= 1'b0;
      ack_hi_q     <= 1'b0;
      sda_oe_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_col_q     <= 7'd0;
      wr_row_q     <= 3'd0;
      wr_data_q    <= 8'd0;
      cmd_valid_q  <= 1'b0;
      cmd_byte_q   <= 8'd0;
      frame_done_q <= 1'b0;
      nack_err_q   <= 1'b0;
      ptr_col_q    <= 7'd0;
      ptr_page_q   <= 3'd0;
      col_start_q  <= 7'd0;
      col_end_q    <= 7'd127;
      page_start_q <= 3'd0;
      page_end_q   <= 3'd7;
      arg_cnt_q    <= 2'd0;
      arg_page_q   <= 1'b0;
      arg0_q       <= 7'd0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_prev_q   <= scl_prev_d;
      sda_prev_q   <= sda_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      co_q         <= co_d;
      dc_q         <= dc_d;
      ack_hi_q     <= ack_hi_d;
      sda_oe_q     <= sda_oe_d;
      wr_en_q      <= wr_en_d;
      wr_col_q     <= wr_col_d;
      wr_row_q     <= wr_row_d;
      wr_data_q    <= wr_data_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_byte_q   <= cmd_byte_d;
      frame_done_q <= frame_done_d;
      nack_err_q   <= nack_err_d;
      ptr_col_q    <= ptr_col_d;
      ptr_page_q   <= ptr_page_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      arg_cnt_q    <= arg_cnt_d;
      arg_page_q   <= arg_page_d;
      arg0_q       <= arg0_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign wr_en      = wr_en_q;
  assign wr_col     = wr_col_q;
  assign wr_row     = wr_row_q;
  assign wr_data    = wr_data_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_byte   = cmd_byte_q;
  assign frame_done = frame_done_q;
  assign nack_err   = nack_err_q;

endmodule

// File: tb/tb_oled_i2c_rx.sv
// tb_oled_i2c_rx: directed I2C master driving the OLED write stream into oled_i2c_rx.
`timescale 1ns/1ps
module tb_oled_i2c_rx;

  localparam int Q = 2;
`ifdef OLED_RX_ACK_EN
  localparam logic ACK_EXP = 1'b1;
`else
  localparam logic ACK_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, scl, sda;
  logic       sda_oe, wr_en, cmd_valid, frame_done, nack_err;
  logic [6:0] wr_col;
  logic [2:0] wr_row;
  logic [7:0] wr_data, cmd_byte;

  int checks = 0;
  int errors = 0;
  int fd_stray = 0;
  int both_cnt = 0;
  logic [18:0] wr_log[$];
  logic [7:0]  cmd_log[$];

  always #5 clk = ~clk;

  oled_i2c_rx #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .sda_oe(sda_oe),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .frame_done(frame_done),
    .nack_err(nack_err)
  );

  // record every output pulse as {frame_done, col, row, data}
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) wr_log.push_back({frame_done, wr_col, wr_row, wr_data});
      else if (frame_done) fd_stray++;
      if (cmd_valid) cmd_log.push_back(cmd_byte);
      if (wr_en && cmd_valid) both_cnt++;
    end
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog got timeout exp finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [18:0] wr_at(input int idx);
    if (idx < wr_log.size()) return wr_log[idx];
    return 19'bx;
  endfunction

  function automatic logic [7:0] cmd_at(input int idx);
    if (idx < cmd_log.size()) return cmd_log[idx];
    return 8'bx;
  endfunction

  task automatic clear_logs();
    wr_log.delete();
    cmd_log.delete();
    fd_stray = 0;
    both_cnt = 0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda = 1'b1; wait_n(Q);
    scl = 1'b1; wait_n(Q);
    sda = 1'b0; wait_n(Q);
    scl = 1'b0; wait_n(Q);
  endtask

  task automatic bus_stop();
    sda = 1'b0; wait_n(Q);
    scl = 1'b1; wait_n(Q);
    sda = 1'b1; wait_n(2 * Q);
  endtask

  task automatic bus_bit(input logic b);
    sda = b;    wait_n(Q);
    scl = 1'b1; wait_n(2 * Q);
    scl = 1'b0; wait_n(Q);
  endtask

  task automatic bus_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bus_bit(b[i]);
    sda = 1'b1; wait_n(Q);
    scl = 1'b1; wait_n(Q);
    ack = sda_oe;
    wait_n(Q);
    scl = 1'b0; wait_n(Q);
  endtask

  task automatic pulse_reset();
    rst = 1'b1; scl = 1'b1; sda = 1'b1;
    wait_n(4);
    rst = 1'b0;
    wait_n(4);
  endtask

  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; sda = 1'b1;
    wait_n(5);
    checks++; if (sda_oe !== 1'b0)     begin errors++; $display("[TB] FAIL reset_sda_oe got %b exp 0", sda_oe); end
    checks++; if (wr_en !== 1'b0)      begin errors++; $display("[TB] FAIL reset_wr_en got %b exp 0", wr_en); end
    checks++; if (wr_col !== 7'd0)     begin errors++; $display("[TB] FAIL reset_wr_col got %0d exp 0", wr_col); end
    checks++; if (wr_row !== 3'd0)     begin errors++; $display("[TB] FAIL reset_wr_row got %0d exp 0", wr_row); end
    checks++; if (wr_data !== 8'd0)    begin errors++; $display("[TB] FAIL reset_wr_data got %h exp 00", wr_data); end
    checks++; if (cmd_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_cmd_valid got %b exp 0", cmd_valid); end
    checks++; if (cmd_byte !== 8'd0)   begin errors++; $display("[TB] FAIL reset_cmd_byte got %h exp 00", cmd_byte); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done got %b exp 0", frame_done); end
    checks++; if (nack_err !== 1'b0)   begin errors++; $display("[TB] FAIL reset_nack_err got %b exp 0", nack_err); end
    rst = 1'b0;
    wait_n(4);
  endtask

  // T1: two data writes then a third transaction shows the pointer reached col 2
  task automatic test_data_write();
    logic a0, a1, a2, ax;
    clear_logs();
    bus_start(); bus_byte(8'h78, a0); bus_byte(8'h40, a1); bus_byte(8'hA5, a2); bus_byte(8'h5A, ax); bus_stop();
    bus_start(); bus_byte(8'h78, ax); bus_byte(8'h40, ax); bus_byte(8'h11, ax); bus_stop();
    checks++; if ({a0, a1, a2} !== {3{ACK_EXP}}) begin errors++; $display("[TB] FAIL t1_acks got %b exp %b", {a0, a1, a2}, {3{ACK_EXP}}); end
    checks++; if (wr_log.size() !== 3) begin errors++; $display("[TB] FAIL t1_wr_count got %0d exp 3", wr_log.size()); end
    checks++; if (wr_at(0) !== {1'b0, 7'd0, 3'd0, 8'hA5}) begin errors++; $display("[TB] FAIL t1_wr0 got %h exp %h", wr_at(0), {1'b0, 7'd0, 3'd0, 8'hA5}); end
    checks++; if (wr_at(1) !== {1'b0, 7'd1, 3'd0, 8'h5A}) begin errors++; $display("[TB] FAIL t1_wr1 got %h exp %h", wr_at(1), {1'b0, 7'd1, 3'd0, 8'h5A}); end
    checks++; if (wr_at(2) !== {1'b0, 7'd2, 3'd0, 8'h11}) begin errors++; $display("[TB] FAIL t1_ptr_col2 got %h exp %h", wr_at(2), {1'b0, 7'd2, 3'd0, 8'h11}); end
    checks++; if (cmd_log.size() !== 0) begin errors++; $display("[TB] FAIL t1_no_cmd got %0d exp 0", cmd_log.size()); end
  endtask

  // T2: window 16..18 x 6..7 then seven data bytes
  task automatic test_window();
    logic ax;
    logic [7:0] exp_cmd[6] = '{8'h21, 8'h10, 8'h12, 8'h22, 8'h06, 8'h07};
    logic [6:0] exp_col[7] = '{7'd16, 7'd17, 7'd18, 7'd16, 7'd17, 7'd18, 7'd16};
    logic [2:0] exp_row[7] = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd6};
    logic [18:0] exp_wr;
    clear_logs();
    bus_start(); bus_byte(8'h78, ax); bus_byte(8'h00, ax);
    for (int i = 0; i < 6; i++) bus_byte(exp_cmd[i], ax);
    bus_stop();
    bus_start(); bus_byte(8'h78, ax); bus_byte(8'h40, ax);
    for (int i = 0; i < 7; i++) bus_byte(8'h01 + 8'(i), ax);
    bus_stop();
    checks++; if (cmd_log.size() !== 6) begin errors++; $display("[TB] FAIL t2_cmd_count got %0d exp 6", cmd_log.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (cmd_at(i) !== exp_cmd[i]) begin errors++; $display("[TB] FAIL t2_cmd%0d got %h exp %h", i, cmd_at(i), exp_cmd[i]); end
    end
    checks++; if (wr_log.size() !== 7) begin errors++; $display("[TB] FAIL t2_wr_count got %0d exp 7", wr_log.size()); end
    for (int i = 0; i < 7; i++) begin
      exp_wr = {(i == 5), exp_col[i], exp_row[i], 8'h01 + 8'(i)};
      checks++; if (wr_at(i) !== exp_wr) begin errors++; $display("[TB] FAIL t2_wr%0d got %h exp %h", i, wr_at(i), exp_wr); end
    end
    checks++; if (fd_stray !== 0) begin errors++; $display("[TB] FAIL t2_stray_frame_done got %0d exp 0", fd_stray); end
  endtask

  // T4: Co=1 single command, then a fresh control byte selects data
  task automatic test_co_path();
    logic ax;
    clear_logs();
    bus_start(); bus_byte(8'h78, ax); bus_byte(8'h80, ax); bus_byte(8'hAF, ax);
    bus_byte(8'h40, ax); bus_byte(8'h33, ax); bus_stop();
    checks++; if (cmd_log.size() !== 1 || cmd_at(0) !== 8'hAF) begin errors++; $display("[TB] FAIL t4_cmd got n=%0d %h exp n=1 af", cmd_log.size(), cmd_at(0)); end
    checks++; if (wr_log.size() !== 1 || wr_at(0) !== {1'b0, 7'd17, 3'd6, 8'h33}) begin errors++; $display("[TB] FAIL t4_wr got n=%0d %h exp n=1 %h", wr_log.size(), wr_at(0), {1'b0, 7'd17, 3'd6, 8'h33}); end
    checks++; if (both_cnt !== 0) begin errors++; $display("[TB] FAIL t4_overlap got %0d exp 0", both_cnt); end
  endtask

  // T3: wrong address and read bit are ignored and flag nack_err
  task automatic test_bad_addr();
    logic a, ax;
    clear_logs();
    checks++; if (nack_err !== 1'b0) begin errors++; $display("[TB] FAIL t3_nack_before got %b exp 0", nack_err); end
    bus_start(); bus_byte(8'h7A, a); bus_byte(8'h40, ax); bus_byte(8'h55, ax); bus_stop();
    checks++; if (a !== 1'b0) begin errors++; $display("[TB] FAIL t3_no_ack got %b exp 0", a); end
    checks++; if (nack_err !== 1'b1) begin errors++; $display("[TB] FAIL t3_nack got %b exp 1", nack_err); end
    checks++; if (wr_log.size() + cmd_log.size() !== 0) begin errors++; $display("[TB] FAIL t3_silent got %0d exp 0", wr_log.size() + cmd_log.size()); end
    bus_start(); bus_byte(8'h78, ax); bus_byte(8'h40, ax); bus_byte(8'h66, ax); bus_stop();
    checks++; if (wr_log.size() !== 1 || wr_at(0) !== {1'b0, 7'd18, 3'd6, 8'h66}) begin errors++; $display("[TB] FAIL t3_recover got n=%0d %h exp n=1 %h", wr_log.size(), wr_at(0), {1'b0, 7'd18, 3'd6, 8'h66}); end
    checks++; if (nack_err !== 1'b1) begin errors++; $display("[TB] FAIL t3_sticky got %b exp 1", nack_err); end
    pulse_reset();
    clear_logs();
    checks++; if (nack_err !== 1'b0) begin errors++; $display("[TB] FAIL t3_nack_cleared got %b exp 0", nack_err); end
    bus_start(); bus_byte(8'h79, a); bus_byte(8'h40, ax); bus_byte(8'h55, ax); bus_stop();
    checks++; if (a !== 1'b0) begin errors++; $display("[TB] FAIL t3_rw_no_ack got %b exp 0", a); end
    checks++; if (nack_err !== 1'b1) begin errors++; $display("[TB] FAIL t3_rw_nack got %b exp 1", nack_err); end
    checks++; if (wr_log.size() + cmd_log.size() !== 0) begin errors++; $display("[TB] FAIL t3_rw_silent got %0d exp 0", wr_log.size() + cmd_log.size()); end
  endtask

  // T6: reset mid-byte, then repeated START mid-byte
  task automatic test_interrupts();
    logic a0, a1, ax;
    pulse_reset();
    bus_start(); bus_byte(8'h78, ax); bus_byte(8'h40, ax);
    bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b0);
    rst = 1'b1; wait_n(3);
    sda = 1'b1; wait_n(Q); scl = 1'b1; wait_n(3);
    rst = 1'b0; wait_n(4);
    clear_logs();
    bus_start(); bus_byte(8'h78, a0); bus_byte(8'h40, a1); bus_byte(8'hA5, ax); bus_byte(8'h5A, ax); bus_stop();
    checks++; if ({a0, a1} !== {2{ACK_EXP}}) begin errors++; $display("[TB] FAIL t6_acks got %b exp %b", {a0, a1}, {2{ACK_EXP}}); end
    checks++; if (wr_log.size() !== 2) begin errors++; $display("[TB] FAIL t6_wr_count got %0d exp 2", wr_log.size()); end
    checks++; if (wr_at(0) !== {1'b0, 7'd0, 3'd0, 8'hA5}) begin errors++; $display("[TB] FAIL t6_wr0 got %h exp %h", wr_at(0), {1'b0, 7'd0, 3'd0, 8'hA5}); end
    checks++; if (wr_at(1) !== {1'b0, 7'd1, 3'd0, 8'h5A}) begin errors++; $display("[TB] FAIL t6_wr1 got %h exp %h", wr_at(1), {1'b0, 7'd1, 3'd0, 8'h5A}); end
    bus_start(); bus_byte(8'h78, ax); bus_byte(8'h40, ax);
    bus_bit(1'b1); bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b0);
    bus_start(); bus_byte(8'h78, ax); bus_byte(8'h40, ax); bus_byte(8'h77, ax); bus_stop();
    checks++; if (wr_log.size() !== 3) begin errors++; $display("[TB] FAIL t6_rs_count got %0d exp 3", wr_log.size()); end
    checks++; if (wr_at(2) !== {1'b0, 7'd2, 3'd0, 8'h77}) begin errors++; $display("[TB] FAIL t6_rs_wr got %h exp %h", wr_at(2), {1'b0, 7'd2, 3'd0, 8'h77}); end
    checks++; if (nack_err !== 1'b0) begin errors++; $display("[TB] FAIL t6_nack got %b exp 0", nack_err); end
  endtask

  // T5: full 128x8 frame on the default window, then one more byte at (0,0)
  task automatic test_frame_wrap();
    logic ax;
    int fd_count, fd_idx;
    pulse_reset();
    clear_logs();
    bus_start(); bus_byte(8'h78, ax); bus_byte(8'h40, ax);
    for (int i = 0; i < 1024; i++) bus_byte(8'(i), ax);
    bus_byte(8'hEE, ax);
    bus_stop();
    fd_count = 0;
    fd_idx = -1;
    foreach (wr_log[i]) if (wr_log[i][18]) begin fd_count++; fd_idx = i; end
    checks++; if (wr_log.size() !== 1025) begin errors++; $display("[TB] FAIL t5_wr_count got %0d exp 1025", wr_log.size()); end
    checks++; if (fd_count !== 1 || fd_idx !== 1023) begin errors++; $display("[TB] FAIL t5_frame_done got n=%0d idx=%0d exp n=1 idx=1023", fd_count, fd_idx); end
    checks++; if (wr_at(127) !== {1'b0, 7'd127, 3'd0, 8'h7F}) begin errors++; $display("[TB] FAIL t5_row0_end got %h exp %h", wr_at(127), {1'b0, 7'd127, 3'd0, 8'h7F}); end
    checks++; if (wr_at(128) !== {1'b0, 7'd0, 3'd1, 8'h80}) begin errors++; $display("[TB] FAIL t5_row1_start got %h exp %h", wr_at(128), {1'b0, 7'd0, 3'd1, 8'h80}); end
    checks++; if (wr_at(1023) !== {1'b1, 7'd127, 3'd7, 8'hFF}) begin errors++; $display("[TB] FAIL t5_last got %h exp %h", wr_at(1023), {1'b1, 7'd127, 3'd7, 8'hFF}); end
    checks++; if (wr_at(1024) !== {1'b0, 7'd0, 3'd0, 8'hEE}) begin errors++; $display("[TB] FAIL t5_wrapped got %h exp %h", wr_at(1024), {1'b0, 7'd0, 3'd0, 8'hEE}); end
    checks++; if (fd_stray !== 0) begin errors++; $display("[TB] FAIL t5_stray_frame_done got %0d exp 0", fd_stray); end
  endtask

  initial begin
    rst = 1'b1;
    scl = 1'b1;
    sda = 1'b1;
    test_reset();
    test_data_write();
    test_window();
    test_co_path();
    test_bad_addr();
    test_interrupts();
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
